// File: rtl/ysyx_23060203_rd_arb.sv
// Two-master AXI read-channel arbiter (m0 = IFU, m1 = LSU) sharing one downstream port.
// One outstanding transaction; ownership is held from AR acceptance through the rlast beat.
module ysyx_23060203_rd_arb #(
  parameter logic RR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [31:0] m0_araddr,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,

  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [31:0] m1_araddr,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,

  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [31:0] s_araddr,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rlast,

  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   arb_grant;
  logic   in_addr;
  logic   in_data;
  logic   sel_arvalid;
  logic   sel_rready;
  logic   ar_fire;
  logic   r_done;

  // Under contention, round-robin hands the port to whoever did not win last time.
  always_comb begin
    arb_grant = 1'b0;
    if (m0_arvalid && m1_arvalid) begin
      arb_grant = RR ? ~last_grant : 1'b1;
    end else begin
      arb_grant = m1_arvalid;
    end
  end

  assign in_addr     = (state == ADDR);
  assign in_data     = (state == DATA);
  assign sel_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign sel_rready  = grant ? m1_rready : m0_rready;
  assign ar_fire     = in_addr && sel_arvalid && s_arready;
  assign r_done      = in_data && s_rvalid && sel_rready && s_rlast;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            grant      <= arb_grant;
            last_grant <= arb_grant;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (ar_fire) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (r_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Address channel: the owner sees the downstream arready, the other master is stalled.
  assign s_arvalid  = in_addr && sel_arvalid;
  assign s_araddr   = grant ? m1_araddr : m0_araddr;
  assign s_arlen    = grant ? m1_arlen : m0_arlen;
  assign s_arsize   = grant ? m1_arsize : m0_arsize;
  assign m0_arready = in_addr && !grant && s_arready;
  assign m1_arready = in_addr && grant && s_arready;

  // Data channel: beats and their payload reach only the owner; termination follows rlast.
  assign s_rready  = in_data && sel_rready;
  assign m0_rvalid = in_data && !grant && s_rvalid;
  assign m1_rvalid = in_data && grant && s_rvalid;
  assign m0_rdata  = (in_data && !grant) ? s_rdata : 32'h0;
  assign m1_rdata  = (in_data && grant) ? s_rdata : 32'h0;
  assign m0_rresp  = (in_data && !grant) ? s_rresp : 2'b00;
  assign m1_rresp  = (in_data && grant) ? s_rresp : 2'b00;
  assign m0_rlast  = in_data && !grant && s_rlast;
  assign m1_rlast  = in_data && grant && s_rlast;

endmodule
